// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 2:1-style mux, with burst hold.
// Optional forced release after MAX_HOLD grant cycles when ARB_TIMEOUT_EN is defined.
module mux_rr_arbiter #(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ-1:0]         last_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] sel_o,
    output logic                       valid_o,
    output logic                       timeout_o
);

    localparam int unsigned SEL_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_HOLD < 1) begin : g_param_check
        $error("mux_rr_arbiter: NUM_REQ must be 2..8 and MAX_HOLD >= 1");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic               valid_q, valid_d;

    logic [SEL_W-1:0]   scan_start;
    logic [SEL_W-1:0]   win_idx;
    logic               win_found;
    logic               owner_req;
    logic               owner_last;
    logic               expire;
    logic               rel;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned    HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              timeout_q, timeout_d;
`endif

    // First set request after 'start', wrapping; 'start' itself is checked last.
    function automatic logic [SEL_W:0] pick(input logic [NUM_REQ-1:0] r,
                                            input logic [SEL_W-1:0]   start);
        logic             found;
        logic [SEL_W-1:0] idx;
        int unsigned      j;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = NUM_REQ; k >= 1; k--) begin
            j = (32'(start) + k) % NUM_REQ;
            if (r[SEL_W'(j)]) begin
                found = 1'b1;
                idx   = SEL_W'(j);
            end
        end
        return {found, idx};
    endfunction

    assign scan_start             = (state_q == GRANT) ? sel_q : ptr_q;
    assign {win_found, win_idx}   = pick(req_i, scan_start);
    assign owner_req              = req_i[sel_q];
    assign owner_last             = last_i[sel_q];

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        expire  = 1'b0;
`ifdef ARB_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
        expire    = (hold_q == HOLD_LAST);
`endif
        rel = !owner_req || owner_last || expire;

        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = GRANT;
                    gnt_d   = NUM_REQ'(1) << win_idx;
                    sel_d   = win_idx;
                    valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end
            end
            GRANT: begin
                if (rel) begin
                    ptr_d = sel_q;
                    if (win_found) begin
                        gnt_d = NUM_REQ'(1) << win_idx;
                        sel_d = win_idx;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        valid_d = 1'b0;
                    end
`ifdef ARB_TIMEOUT_EN
                    hold_d    = '0;
                    // last or a dropped request on the expiry edge is an ordinary release
                    timeout_d = expire && owner_req && !owner_last;
`endif
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= SEL_W'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    assign gnt_o   = gnt_q;
    assign sel_o   = sel_q;
    assign valid_o = valid_q;

endmodule
